lm_sm_sequencer: RTL and testbench

Multi-register transfer sequencer for LM/SM in the IITB-RISC pipeline. It sits beside `controller` in the register-read stage. It walks the 8-bit register list of an LM (opcode 0110) or SM (opcode 0111) one register per step, lowest index first, and produces three signals. `pe_out` is the register address for the RF address mux. `is_one_hot_or_zero` is the signal `controller` uses to gate `Load_PC`. `first` selects the base register versus the incremented address into ALU input 1. It also stalls fetch/decode until the last transfer issues.

---
 rtl/iitb_risc_pkg.sv | 24 ++
 rtl/lm_sm_sequencer_if.sv | 50 +++++
 rtl/lm_sm_sequencer_priority_encoder8.sv | 33 +++
 rtl/lm_sm_sequencer.sv | 101 ++++++++++
 tb/tb_lm_sm_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/iitb_risc_pkg.sv
// Shared IITB-RISC definitions used by the LM/SM sequencer.
// Contents:
//   NREG, AW     - architectural register count and register address width
//   OP_LM, OP_SM - opcodes of the multi-register load/store instructions
//   lmsm_state_e - sequencer FSM state type
//   is_lmsm_op   - opcode decode helper
package iitb_risc_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } lmsm_state_e;

  function automatic logic is_lmsm_op(logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Register-read-stage bundle between the pipeline and the LM/SM sequencer.
// Signals:
//   instruction, valid, advance, flush - pipeline to sequencer
//   busy, xfer_valid, pe_out, is_one_hot_or_zero, first, stall_fetch - sequencer to pipeline
// Modports:
//   master - the pipeline side (drives instruction/valid/advance/flush)
//   slave  - the sequencer side
interface lm_sm_sequencer_if #(
  parameter int unsigned AW = 3
);

  logic [15:0]   instruction;
  logic          valid;
  logic          advance;
  logic          flush;

  logic          busy;
  logic          xfer_valid;
  logic [AW-1:0] pe_out;
  logic          is_one_hot_or_zero;
  logic          first;
  logic          stall_fetch;

  modport master (
    output instruction,
    output valid,
    output advance,
    output flush,
    input  busy,
    input  xfer_valid,
    input  pe_out,
    input  is_one_hot_or_zero,
    input  first,
    input  stall_fetch
  );

  modport slave (
    input  instruction,
    input  valid,
    input  advance,
    input  flush,
    output busy,
    output xfer_valid,
    output pe_out,
    output is_one_hot_or_zero,
    output first,
    output stall_fetch
  );

endinterface

// File: rtl/lm_sm_sequencer_priority_encoder8.sv
// Lowest-index-first priority encoder over an 8-bit register list.
// Ports:
//   mask               - register list to encode
//   pe_out             - index of the lowest set bit (0 when mask is empty)
//   mask_clr           - mask with its lowest set bit cleared
//   is_one_hot_or_zero - popcount(mask) <= 1
//   nonzero            - mask has at least one bit set
module priority_encoder8
  import iitb_risc_pkg::*;
(
  input  logic [NREG-1:0] mask,
  output logic [AW-1:0]   pe_out,
  output logic [NREG-1:0] mask_clr,
  output logic            is_one_hot_or_zero,
  output logic            nonzero
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    pe_out = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) begin
        pe_out = AW'(i);
      end
    end
  end

  // x & (x - 1) drops the lowest set bit; an empty result means at most one bit was set.
  assign mask_clr           = mask & (mask - NREG'(1));
  assign is_one_hot_or_zero = (mask_clr == '0);
  assign nonzero            = |mask;

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-register transfer sequencer for the register-read stage.
// Walks the 8-bit register list of an LM/SM one register per advancing cycle, R0 first,
// and stalls fetch/decode until the last transfer issues.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of lm_sm_sequencer_if (instruction/valid/advance/flush in,
//           busy/xfer_valid/pe_out/is_one_hot_or_zero/first/stall_fetch out)
module lm_sm_sequencer #(
  parameter int unsigned NREG = iitb_risc_pkg::NREG,
  parameter int unsigned AW   = iitb_risc_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  lm_sm_sequencer_if.slave  bus
);

  import iitb_risc_pkg::*;

  lmsm_state_e     state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d;

  logic            is_lmsm;
  logic [NREG-1:0] mask_cur;
  logic [AW-1:0]   pe_idx;
  logic [NREG-1:0] pe_clr;
  logic            pe_ohz;
  logic            pe_nonzero;

  // Register-number and immediate bits between the opcode and the list are not needed here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[11:NREG];

  assign is_lmsm = bus.valid && is_lmsm_op(bus.instruction[15:12]);

  // The list is read from the instruction only in IDLE; afterwards the remaining bits live
  // in mask_q, so the held instruction register is never re-decoded mid-sequence.
  always_comb begin
    mask_cur = '0;
    if (is_lmsm) begin
      mask_cur = (state_q == StIdle) ? bus.instruction[NREG-1:0] : mask_q;
    end
  end

  priority_encoder8 u_pe (
    .mask               (mask_cur),
    .pe_out             (pe_idx),
    .mask_clr           (pe_clr),
    .is_one_hot_or_zero (pe_ohz),
    .nonzero            (pe_nonzero)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (bus.flush) begin
      state_d = StIdle;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // One-hot and empty lists finish in their only cycle and never enter XFER.
          if (is_lmsm && bus.advance && !pe_ohz) begin
            mask_d  = pe_clr;
            state_d = StXfer;
          end
        end
        StXfer: begin
          if (bus.advance) begin
            if (pe_ohz) begin
              mask_d  = '0;
              state_d = StIdle;
            end else begin
              mask_d = pe_clr;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    bus.busy               = (state_q == StXfer);
    bus.first              = (state_q == StIdle);
    bus.pe_out             = pe_idx;
    bus.is_one_hot_or_zero = is_lmsm ? pe_ohz : 1'b1;
    bus.xfer_valid         = is_lmsm && pe_nonzero;
    bus.stall_fetch        = is_lmsm && !pe_ohz;
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: per-cycle expected outputs are queued when the
// stimulus is driven and popped/compared when the outputs are sampled on the falling edge.
module tb_lm_sm_sequencer;

  logic clk;
  logic rst_n;

  lm_sm_sequencer_if #(.AW(3)) bus ();

  lm_sm_sequencer #(
    .NREG (8),
    .AW   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       xv;
    logic [2:0] pe;
    logic       ohz;
    logic       fst;
    logic       stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   xfer_cnt = 0;

  function automatic exp_t ev(logic busy, logic xv, logic [2:0] pe, logic ohz, logic fst,
                              logic stall);
    exp_t e;
    e.busy  = busy;
    e.xv    = xv;
    e.pe    = pe;
    e.ohz   = ohz;
    e.fst   = fst;
    e.stall = stall;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input string tag, input logic [15:0] ins, input logic v, input logic a,
                      input logic f, input logic r, input exp_t e);
    exp_t want;
    bus.instruction = ins;
    bus.valid       = v;
    bus.advance     = a;
    bus.flush       = f;
    rst_n           = r;
    exp_q.push_back(e);
    @(negedge clk);
    if (bus.xfer_valid && a) xfer_cnt++;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 8'd0, 8'd1);
    end else begin
      want = exp_q.pop_front();
      check_eq({tag, ".busy"},  {7'd0, bus.busy},               {7'd0, want.busy});
      check_eq({tag, ".xv"},    {7'd0, bus.xfer_valid},         {7'd0, want.xv});
      check_eq({tag, ".pe"},    {5'd0, bus.pe_out},             {5'd0, want.pe});
      check_eq({tag, ".ohz"},   {7'd0, bus.is_one_hot_or_zero}, {7'd0, want.ohz});
      check_eq({tag, ".first"}, {7'd0, bus.first},              {7'd0, want.fst});
      check_eq({tag, ".stall"}, {7'd0, bus.stall_fetch},        {7'd0, want.stall});
    end
    @(posedge clk);
    #1;
  endtask

  exp_t idle_e;
  int   pe_tab[10];

  initial begin
    idle_e = ev(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    pe_tab = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};

    bus.instruction = 16'h0000;
    bus.valid       = 1'b0;
    bus.advance     = 1'b0;
    bus.flush       = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values with valid low
    step("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, idle_e);

    // LM 0x25: R0, R2, R5
    step("lm25.c1", 16'h6025, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("lm25.c2", 16'h6025, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1));
    step("lm25.c3", 16'h6025, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0));
    step("lm25.c4", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);

    // SM 0x80: single one-hot transfer, never busy
    step("sm80.c1", 16'h7180, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0));
    step("sm80.c2", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);

    // LM 0x00: empty list, one cycle, no transfer, no stall
    step("lm00.c1", 16'h6200, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
    step("lm00.c2", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);

    // Non-LM/SM opcode with a list-like low byte stays idle
    step("alu.c1", 16'h1025, 1'b1, 1'b1, 1'b0, 1'b1, idle_e);

    // LM in IDLE without advance: outputs present, no state change
    step("lm03.hold", 16'h6003, 1'b1, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("lm03.hold2", 16'h6003, 1'b1, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("lm03.c1", 16'h6003, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("lm03.c2", 16'h6003, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
    step("lm03.c3", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);

    // SM 0xFF with advance low on cycles 3-4
    xfer_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      logic a;
      a = !(c == 3 || c == 4);
      step($sformatf("smff.c%0d", c), 16'h70FF, 1'b1, a, 1'b0, 1'b1,
           ev(c != 1, 1'b1, 3'(pe_tab[c-1]), c == 10, c == 1, c != 10));
    end
    check_eq("smff.count", 8'(xfer_cnt), 8'd8);
    step("smff.idle", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);

    // LM 0x0F with flush alongside advance in the 2nd cycle
    xfer_cnt = 0;
    step("fl.c1", 16'h600F, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("fl.c2", 16'h600F, 1'b1, 1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1));
    step("fl.c3", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);
    step("fl.c4", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);
    check_eq("fl.count", 8'(xfer_cnt), 8'd2);

    // Same with reset in the 2nd cycle
    xfer_cnt = 0;
    step("rs.c1", 16'h600F, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1));
    step("rs.c2", 16'h600F, 1'b1, 1'b1, 1'b0, 1'b0, ev(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1));
    step("rs.c3", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);
    step("rs.c4", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, idle_e);
    check_eq("rs.count", 8'(xfer_cnt), 8'd2);

    // After the flush, a fresh one-hot LM must read its list from the instruction again
    step("post.c1", 16'h6010, 1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
